rr_arb_param: RTL and testbench

RR_ARB_PARAM -- requirements
Module: rr_arb_param

---
 rtl/rr_arb_param_if.sv | 14 +
 rtl/rr_arb_param.sv | 106 ++++++++++
 tb/tb_rr_arb_param.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/rr_arb_param_if.sv
// rtl/rr_arb_param_if.sv - request/grant bundle shared by requesters and the round-robin arbiter
interface rr_arb_param_if #(
   parameter int N = 4
);
   localparam int W = (N > 1) ? $clog2(N) : 1;

   logic [N-1:0] req;
   logic [N-1:0] gnt;
   logic         gnt_valid;
   logic [W-1:0] gnt_id;

   modport master (output req, input gnt, input gnt_valid, input gnt_id);
   modport slave  (input req, output gnt, output gnt_valid, output gnt_id);
endinterface

// File: rtl/rr_arb_param.sv
// rtl/rr_arb_param.sv - round-robin arbiter with bounded grant hold and registered one-hot grant
module rr_arb_param #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 4,
   parameter int HOLD_EN  = 1
) (
   input logic           clk,
   input logic           reset,
   rr_arb_param_if.slave bus
);
   localparam int W = (N > 1) ? $clog2(N) : 1;
   localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

   typedef logic [W-1:0] idx_t;
   typedef enum logic {IDLE, GRANT} state_t;

   state_t       state;
   idx_t         ptr;
   idx_t         owner;
   logic [7:0]   hold_cnt;

   logic [N-1:0] owner_oh;
   logic [N-1:0] others;
   logic [N-1:0] search_mask;
   logic [N-1:0] pick_oh;
   logic         owner_req;
   logic         hold_ok;
   logic         pick_found;
   idx_t         pick_idx;
   idx_t         cand;
   idx_t         ptr_next;
   logic         take;
   logic         drop;

   always_comb begin
      owner_oh = '0;
      owner_oh[owner] = 1'b1;
   end

   assign others      = bus.req & ~owner_oh;
   assign owner_req   = |(bus.req & owner_oh);
   assign hold_ok     = (HOLD_EN != 0) && (hold_cnt < HOLD_MAX);
   // While granting, the owner is never a candidate: it either released or is being rotated away from.
   assign search_mask = (state == GRANT) ? others : bus.req;

   // Scanning downward lets the candidate closest to ptr overwrite the rest.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int i = N - 1; i >= 0; i--) begin
         cand = idx_t'((int'(ptr) + i) % N);
         if (search_mask[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   always_comb begin
      pick_oh = '0;
      pick_oh[pick_idx] = 1'b1;
      ptr_next = (pick_idx == idx_t'(N - 1)) ? '0 : pick_idx + idx_t'(1);
   end

   always_comb begin
      take = 1'b0;
      drop = 1'b0;
      if (state == IDLE) begin
         take = pick_found;
      end else if (!owner_req) begin
         take = pick_found;
         drop = !pick_found;
      end else if ((others != '0) && !hold_ok) begin
         take = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         ptr           <= '0;
         owner         <= '0;
         hold_cnt      <= '0;
         bus.gnt       <= '0;
         bus.gnt_valid <= 1'b0;
         bus.gnt_id    <= '0;
      end else if (take) begin
         state         <= GRANT;
         ptr           <= ptr_next;
         owner         <= pick_idx;
         hold_cnt      <= 8'd1;
         bus.gnt       <= pick_oh;
         bus.gnt_valid <= 1'b1;
         bus.gnt_id    <= pick_idx;
      end else if (drop) begin
         state         <= IDLE;
         hold_cnt      <= '0;
         bus.gnt       <= '0;
         bus.gnt_valid <= 1'b0;
         bus.gnt_id    <= '0;
      end else if ((state == GRANT) && (hold_cnt < HOLD_MAX)) begin
         hold_cnt <= hold_cnt + 8'd1;
      end
   end
endmodule

// File: tb/tb_rr_arb_param.sv
// tb/tb_rr_arb_param.sv - directed vector bench for rr_arb_param in hold and rotate modes
module tb_rr_arb_param;
   logic clk = 1'b0;
   logic reset;
   logic mon_en = 1'b0;
   int   nvec = 0;
   int   nerr = 0;

   always #5 clk = ~clk;

   rr_arb_param_if #(.N(4)) bus_h ();
   rr_arb_param_if #(.N(4)) bus_r ();

   rr_arb_param #(.N(4), .MAX_HOLD(4), .HOLD_EN(1)) dut_h (.clk(clk), .reset(reset), .bus(bus_h));
   rr_arb_param #(.N(4), .MAX_HOLD(4), .HOLD_EN(0)) dut_r (.clk(clk), .reset(reset), .bus(bus_r));

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic [3:0] eh;
      logic [3:0] er;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic rst, input logic [3:0] req,
                               input logic [3:0] eh, input logic [3:0] er);
      vec_t v;
      v.rst = rst; v.req = req; v.eh = eh; v.er = er;
      tbl.push_back(v);
   endfunction

   function automatic logic [1:0] enc(input logic [3:0] g);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 3; i >= 0; i--) if (g[i]) r = 2'(i);
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_h(input string tag, input logic [3:0] e);
      chk({tag, ".h.gnt"}, 32'(bus_h.gnt), 32'(e));
      chk({tag, ".h.valid"}, 32'(bus_h.gnt_valid), 32'(|e));
      chk({tag, ".h.id"}, 32'(bus_h.gnt_id), 32'(enc(e)));
   endtask

   task automatic chk_r(input string tag, input logic [3:0] e);
      chk({tag, ".r.gnt"}, 32'(bus_r.gnt), 32'(e));
      chk({tag, ".r.valid"}, 32'(bus_r.gnt_valid), 32'(|e));
      chk({tag, ".r.id"}, 32'(bus_r.gnt_id), 32'(enc(e)));
   endtask

   task automatic apply(input logic rst, input logic [3:0] req);
      @(negedge clk);
      reset     = rst;
      bus_h.req = req;
      bus_r.req = req;
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         chk("onehot.h", 32'($onehot0(bus_h.gnt)), 32'd1);
         chk("onehot.r", 32'($onehot0(bus_r.gnt)), 32'd1);
      end
   end

   initial begin
      int n;
      reset     = 1'b1;
      bus_h.req = '0;
      bus_r.req = '0;

      // all four requesting: hold mode walks in blocks of four, rotate mode every cycle
      add(1'b1, 4'hF, 4'h0, 4'h0);
      for (int i = 0; i < 17; i++)
         add(1'b0, 4'hF, 4'b0001 << ((i / 4) % 4), 4'b0001 << (i % 4));
      // single requester 2 for two cycles, then release
      add(1'b1, 4'h0, 4'h0, 4'h0);
      add(1'b0, 4'h4, 4'h4, 4'h4);
      add(1'b0, 4'h4, 4'h4, 4'h4);
      add(1'b0, 4'h0, 4'h0, 4'h0);
      // owner 1, requester 3 waits, owner releases: hand-off without a bubble
      add(1'b0, 4'h2, 4'h2, 4'h2);
      add(1'b0, 4'hA, 4'h2, 4'h8);
      add(1'b0, 4'h8, 4'h8, 4'h8);
      add(1'b0, 4'h0, 4'h0, 4'h0);
      // lone long holder, then a competitor arrives after saturation
      for (int i = 0; i < 20; i++) add(1'b0, 4'h4, 4'h4, 4'h4);
      add(1'b0, 4'h5, 4'h1, 4'h1);
      add(1'b0, 4'h5, 4'h1, 4'h4);
      add(1'b0, 4'h0, 4'h0, 4'h0);
      // two requesters from reset
      add(1'b1, 4'hA, 4'h0, 4'h0);
      for (int i = 0; i < 6; i++)
         add(1'b0, 4'hA, (i < 4) ? 4'h2 : 4'h8, (i % 2 == 0) ? 4'h2 : 4'h8);

      foreach (tbl[i]) begin
         apply(tbl[i].rst, tbl[i].req);
         mon_en = 1'b1;
         chk_h($sformatf("v%0d", i), tbl[i].eh);
         chk_r($sformatf("v%0d", i), tbl[i].er);
      end

      // pointer parks after the granted index once the grant is released
      apply(1'b1, 4'h0);
      apply(1'b0, 4'h4);
      apply(1'b0, 4'h4);
      apply(1'b0, 4'h0);
      chk_h("release", 4'h0);
      chk("release.ptr", 32'(dut_h.ptr), 32'd3);

      // hold counter saturates instead of wrapping
      for (int i = 0; i < 20; i++) begin
         apply(1'b0, 4'h4);
         if (i == 2) chk("hold.cnt3", 32'(dut_h.hold_cnt), 32'd3);
      end
      chk_h("hold.sat", 4'h4);
      chk("hold.cnt_sat", 32'(dut_h.hold_cnt), 32'd4);
      apply(1'b0, 4'h5);
      chk_h("hold.rotate", 4'h1);

      // reset while owner 2 holds
      apply(1'b1, 4'hF);
      for (int i = 0; i < 9; i++) apply(1'b0, 4'hF);
      chk_h("midrst.owner2", 4'h4);
      apply(1'b1, 4'hF);
      chk_h("midrst.rst", 4'h0);
      chk("midrst.ptr", 32'(dut_h.ptr), 32'd0);
      chk("midrst.hold", 32'(dut_h.hold_cnt), 32'd0);
      apply(1'b0, 4'hF);
      chk_h("midrst.first", 4'h1);

      // requester 3 under full contention is first served at the starvation bound
      apply(1'b1, 4'hF);
      n = 0;
      while (n < 20) begin
         apply(1'b0, 4'hF);
         n++;
         if (bus_h.gnt[3]) break;
      end
      chk("starve.cycles", 32'(n), 32'd13);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
